opicorv32_mem_ctrl: RTL and testbench
=====================================

OPICORV32_MEM_CTRL -- requirements
Module: opicorv32_mem_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have request inputs from the control block, each 1 bit: mem_do_prefetch, mem_do_rinst, mem_do_rdata, mem_do_wdata, trap.
REQ-004 SHALL have input mem_wordsize, 2 bits: 0 = word, 1 = half, 2 = byte; 3 is treated as word.
REQ-005 SHALL have address and data inputs, each 32 bits: next_pc (fetch address), reg_op1 (data address), reg_op2 (store data).
REQ-006 SHALL have outputs to the control block: mem_done (1 bit) and mem_rdata_word (32 bits).
REQ-007 SHALL have bus outputs: mem_valid (1), mem_instr (1), mem_addr (32), mem_wdata (32), mem_wstrb (4).
REQ-008 SHALL have bus inputs: mem_ready (1) and mem_rdata (32).

Function
REQ-009 SHALL implement a 2-bit state register with states IDLE=0, RWAIT=1, WWAIT=2, PREF=3.
REQ-010 SHALL define xfer = mem_valid & mem_ready.
REQ-011 In IDLE with trap=0, if prefetch, rinst or rdata is set, SHALL register mem_valid=1, mem_wstrb=0 and mem_instr=(prefetch|rinst), then go to RWAIT.
REQ-012 In IDLE with trap=0, if only wdata is set, SHALL register mem_valid=1 and mem_instr=0, then go to WWAIT.
REQ-013 In IDLE, read requests SHALL take priority over wdata.
REQ-014 In IDLE, trap=1 SHALL block any new request.
REQ-015 For an instruction request, mem_addr SHALL be next_pc with bits [1:0] forced to 0.
REQ-016 For a data request, mem_addr SHALL be reg_op1 with bits [1:0] forced to 0.
REQ-017 mem_addr, mem_wdata and mem_wstrb SHALL be registered at issue and held stable while mem_valid=1.
REQ-018 Store data and strobes, with a = reg_op1[1:0]:
- word: wdata = reg_op2; wstrb = 1111.
- half: wdata = {2{reg_op2[15:0]}}; wstrb = 0011 if a[1]=0, else 1100.
- byte: wdata = {4{reg_op2[7:0]}}; wstrb = 0001 shifted left by a.
REQ-019 In RWAIT on xfer, SHALL clear mem_valid; next state is IDLE if rinst|rdata is set, otherwise PREF.
REQ-020 In WWAIT on xfer, SHALL clear mem_valid and mem_wstrb and go to IDLE.
REQ-021 In PREF, SHALL stay until mem_do_rinst=1, then go to IDLE; no bus activity occurs in PREF.
REQ-022 mem_done SHALL be combinational and equal (xfer & state≠IDLE & (rinst|rdata|wdata)) | (state=PREF & rinst).
REQ-023 A prefetch completing alone SHALL NOT assert mem_done.
REQ-024 mem_rdata_word SHALL be combinational from the data source D, zero-extended:
- word: D.
- half: D[15:0] if a[1]=0, else D[31:16].
- byte: the byte of D selected by a.
REQ-025 Bus latency SHALL be 1 cycle from request to mem_valid; mem_done SHALL assert in the same cycle as mem_ready; mem_ready may be held low indefinitely.
REQ-026 mem_ready while mem_valid=0 SHALL be ignored.
REQ-027 Request changes while in RWAIT or WWAIT SHALL NOT alter bus outputs.

Reset
REQ-028 When reset=1 at a clock edge, the following SHALL hold on the next cycle: state=IDLE, mem_valid=0, mem_instr=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, and the held-data register=0.
REQ-029 While reset=1, mem_done SHALL be forced to 0.
REQ-030 Reset during RWAIT or WWAIT SHALL abandon the transfer with no mem_done pulse.

Configuration
REQ-031 The feature macro SHALL be named OPICORV32_MEM_RDATA_HOLD_EN.
REQ-032 With OPICORV32_MEM_RDATA_HOLD_EN defined, SHALL:
- capture mem_rdata into a 32-bit register on every read xfer;
- use D = xfer ? mem_rdata : held register;
- hence keep mem_rdata_word stable after the transfer until the next read.
REQ-033 With OPICORV32_MEM_RDATA_HOLD_EN undefined, SHALL use D = mem_rdata directly, with no holding register.

Verification
REQ-034 Fetch: rinst=1, next_pc=0x00000106, mem_ready asserted 3 cycles after mem_valid, mem_rdata=0x12345678 -> mem_addr=0x00000104, mem_instr=1, mem_done=1 for exactly 1 cycle, mem_rdata_word=0x12345678, state returns to IDLE.
REQ-035 Byte store: wdata=1, mem_wordsize=2, reg_op1=0x203, reg_op2=0xA5 -> mem_addr=0x200, mem_wdata=0xA5A5A5A5, mem_wstrb=1000, mem_instr=0; on xfer mem_done=1 and wstrb=0.
REQ-036 Half load: rdata=1, mem_wordsize=1, reg_op1=0x1002, mem_rdata=0xBEEF1234 -> mem_rdata_word=0x0000BEEF.
REQ-037 Prefetch then claim: prefetch=1 with xfer -> no mem_done, state=PREF; 5 cycles later rinst=1 -> mem_done=1 that cycle with no new mem_valid; with the macro defined, mem_rdata_word equals the prefetched data.
REQ-038 Abort/priority: reset asserted while in RWAIT -> mem_valid=0 next cycle and no mem_done; rdata=1 and wdata=1 together in IDLE -> read issued (state RWAIT, wstrb=0); trap=1 in IDLE -> mem_valid remains 0.

Source files
------------

// File: rtl/opicorv32_mem_ctrl.sv
// opicorv32_mem_ctrl: single-outstanding memory bus sequencer for the core.
// Issues fetch/load/store transfers, formats store data and strobes, and
// aligns/zero-extends read data for the control block.
// Optional build macro OPICORV32_MEM_RDATA_HOLD_EN: keeps the last read word
// in a holding register so mem_rdata_word stays valid after the transfer.
//
// state | meaning
// IDLE  | no transfer outstanding, accepts new requests
// RWAIT | read (fetch or load) on the bus, waiting for mem_ready
// WWAIT | store on the bus, waiting for mem_ready
// PREF  | prefetched word returned, waiting for the fetch to claim it
module opicorv32_mem_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_do_prefetch,
    input  logic        mem_do_rinst,
    input  logic        mem_do_rdata,
    input  logic        mem_do_wdata,
    input  logic        trap,
    input  logic [1:0]  mem_wordsize,
    input  logic [31:0] next_pc,
    input  logic [31:0] reg_op1,
    input  logic [31:0] reg_op2,
    output logic        mem_done,
    output logic [31:0] mem_rdata_word,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RWAIT = 2'd1,
        WWAIT = 2'd2,
        PREF  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        valid_nxt, instr_nxt;
    logic [31:0] addr_nxt, wdata_nxt;
    logic [3:0]  wstrb_nxt;
    logic [31:0] store_data;
    logic [3:0]  store_strb;
    logic [31:0] rdata_src;
    logic [1:0]  a;
    logic        xfer;
    logic        instr_req, read_req;

    assign a         = reg_op1[1:0];
    assign xfer      = mem_valid & mem_ready;
    assign instr_req = mem_do_prefetch | mem_do_rinst;
    assign read_req  = instr_req | mem_do_rdata;

    // Store lane replication and byte-enable generation from size and offset.
    always_comb begin
        store_data = reg_op2;
        store_strb = 4'b1111;
        case (mem_wordsize)
            2'd1: begin
                store_data = {2{reg_op2[15:0]}};
                store_strb = a[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                store_data = {4{reg_op2[7:0]}};
                store_strb = 4'b0001 << a;
            end
            default: begin
                store_data = reg_op2;
                store_strb = 4'b1111;
            end
        endcase
    end

    // State register and registered bus outputs; reset abandons any transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_instr <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'd0;
        end else begin
            state     <= state_nxt;
            mem_valid <= valid_nxt;
            mem_instr <= instr_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            mem_wstrb <= wstrb_nxt;
        end
    end

    // Next-state and bus-output updates; bus fields only change at issue or completion.
    always_comb begin
        state_nxt = state;
        valid_nxt = mem_valid;
        instr_nxt = mem_instr;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        wstrb_nxt = mem_wstrb;
        case (state)
            IDLE: begin
                if (!trap) begin
                    if (read_req) begin
                        valid_nxt = 1'b1;
                        wstrb_nxt = 4'd0;
                        instr_nxt = instr_req;
                        addr_nxt  = instr_req ? {next_pc[31:2], 2'b00}
                                              : {reg_op1[31:2], 2'b00};
                        state_nxt = RWAIT;
                    end else if (mem_do_wdata) begin
                        valid_nxt = 1'b1;
                        instr_nxt = 1'b0;
                        addr_nxt  = {reg_op1[31:2], 2'b00};
                        wdata_nxt = store_data;
                        wstrb_nxt = store_strb;
                        state_nxt = WWAIT;
                    end
                end
            end
            RWAIT: begin
                if (xfer) begin
                    valid_nxt = 1'b0;
                    state_nxt = (mem_do_rinst | mem_do_rdata) ? IDLE : PREF;
                end
            end
            WWAIT: begin
                if (xfer) begin
                    valid_nxt = 1'b0;
                    wstrb_nxt = 4'd0;
                    state_nxt = IDLE;
                end
            end
            PREF: begin
                if (mem_do_rinst) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Completion pulse: a bus transfer the control block asked for, or a claimed prefetch.
    always_comb begin
        mem_done = ((xfer & (state != IDLE) & (mem_do_rinst | mem_do_rdata | mem_do_wdata))
                    | ((state == PREF) & mem_do_rinst)) & ~reset;
    end

`ifdef OPICORV32_MEM_RDATA_HOLD_EN
    logic [31:0] rdata_hold;

    // Capture every returned read word so a later claim still sees it.
    always_ff @(posedge clk) begin
        if (reset)
            rdata_hold <= 32'd0;
        else if (xfer && state == RWAIT)
            rdata_hold <= mem_rdata;
    end

    assign rdata_src = xfer ? mem_rdata : rdata_hold;
`else
    assign rdata_src = mem_rdata;
`endif

    // Lane select and zero extension of the read word by size and offset.
    always_comb begin
        mem_rdata_word = rdata_src;
        case (mem_wordsize)
            2'd1: mem_rdata_word = a[1] ? {16'd0, rdata_src[31:16]} : {16'd0, rdata_src[15:0]};
            2'd2: begin
                case (a)
                    2'd0:    mem_rdata_word = {24'd0, rdata_src[7:0]};
                    2'd1:    mem_rdata_word = {24'd0, rdata_src[15:8]};
                    2'd2:    mem_rdata_word = {24'd0, rdata_src[23:16]};
                    default: mem_rdata_word = {24'd0, rdata_src[31:24]};
                endcase
            end
            default: mem_rdata_word = rdata_src;
        endcase
    end

endmodule

// File: tb/tb_opicorv32_mem_ctrl.sv
// Directed bench for opicorv32_mem_ctrl: fetch, stores, loads, prefetch claim,
// reset abort, request priority and trap blocking.
module tb_opicorv32_mem_ctrl;

    localparam int S_IDLE  = 0;
    localparam int S_RWAIT = 1;
    localparam int S_WWAIT = 2;
    localparam int S_PREF  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_do_prefetch, mem_do_rinst, mem_do_rdata, mem_do_wdata, trap;
    logic [1:0]  mem_wordsize;
    logic [31:0] next_pc, reg_op1, reg_op2;
    logic        mem_done;
    logic [31:0] mem_rdata_word;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    opicorv32_mem_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .mem_do_prefetch(mem_do_prefetch),
        .mem_do_rinst   (mem_do_rinst),
        .mem_do_rdata   (mem_do_rdata),
        .mem_do_wdata   (mem_do_wdata),
        .trap           (trap),
        .mem_wordsize   (mem_wordsize),
        .next_pc        (next_pc),
        .reg_op1        (reg_op1),
        .reg_op2        (reg_op2),
        .mem_done       (mem_done),
        .mem_rdata_word (mem_rdata_word),
        .mem_valid      (mem_valid),
        .mem_instr      (mem_instr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // one full cycle, landing on the next falling edge
    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_req();
        mem_do_prefetch = 1'b0;
        mem_do_rinst    = 1'b0;
        mem_do_rdata    = 1'b0;
        mem_do_wdata    = 1'b0;
        trap            = 1'b0;
        mem_ready       = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_req();
        mem_wordsize = 2'd0;
        next_pc = 32'd0;
        reg_op1 = 32'd0;
        reg_op2 = 32'd0;
        mem_rdata = 32'd0;
        step();
        step();

        // reset state
        check("rst_valid", mem_valid, 0);
        check("rst_instr", mem_instr, 0);
        check("rst_addr",  mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_wstrb", mem_wstrb, 0);
        check("rst_state", 32'(dut.state), S_IDLE);
        check("rst_done",  mem_done, 0);

        // fetch with 3-cycle bus latency
        reset = 1'b0;
        mem_do_rinst = 1'b1;
        next_pc = 32'h0000_0106;
        step();
        check("f_valid", mem_valid, 1);
        check("f_addr",  mem_addr, 32'h0000_0104);
        check("f_instr", mem_instr, 1);
        check("f_wstrb", mem_wstrb, 0);
        check("f_state", 32'(dut.state), S_RWAIT);
        check("f_done0", mem_done, 0);
        next_pc = 32'h0000_0300;
        for (int i = 0; i < 2; i++) begin
            step();
            check("f_hold_addr", mem_addr, 32'h0000_0104);
            check("f_wait_done", mem_done, 0);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        check("f_done",  mem_done, 1);
        check("f_rword", mem_rdata_word, 32'h1234_5678);
        step();
        mem_do_rinst = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("f_done_1cyc", mem_done, 0);
        check("f_valid_clr", mem_valid, 0);
        check("f_state_end", 32'(dut.state), S_IDLE);

        // byte store at offset 3
        mem_do_wdata = 1'b1;
        mem_wordsize = 2'd2;
        reg_op1 = 32'h0000_0203;
        reg_op2 = 32'h0000_00A5;
        step();
        check("sb_valid", mem_valid, 1);
        check("sb_addr",  mem_addr, 32'h0000_0200);
        check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        check("sb_wstrb", mem_wstrb, 4'b1000);
        check("sb_instr", mem_instr, 0);
        check("sb_state", 32'(dut.state), S_WWAIT);
        reg_op2 = 32'h0000_00FF;
        reg_op1 = 32'h0000_0400;
        step();
        check("sb_hold_wdata", mem_wdata, 32'hA5A5_A5A5);
        check("sb_hold_addr",  mem_addr, 32'h0000_0200);
        mem_ready = 1'b1;
        #1;
        check("sb_done", mem_done, 1);
        step();
        clear_req();
        #1;
        check("sb_wstrb_clr", mem_wstrb, 0);
        check("sb_valid_clr", mem_valid, 0);
        check("sb_state_end", 32'(dut.state), S_IDLE);

        // half store, upper half
        mem_do_wdata = 1'b1;
        mem_wordsize = 2'd1;
        reg_op1 = 32'h0000_0012;
        reg_op2 = 32'h1234_ABCD;
        step();
        check("sh_addr",  mem_addr, 32'h0000_0010);
        check("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        check("sh_wstrb", mem_wstrb, 4'b1100);
        mem_ready = 1'b1;
        step();
        clear_req();

        // wordsize 3 behaves as word
        mem_do_wdata = 1'b1;
        mem_wordsize = 2'd3;
        reg_op1 = 32'h0000_0301;
        reg_op2 = 32'hDEAD_BEEF;
        step();
        check("sw_addr",  mem_addr, 32'h0000_0300);
        check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("sw_wstrb", mem_wstrb, 4'b1111);
        mem_ready = 1'b1;
        step();
        clear_req();

        // half load, upper half, plus lane selects on the same beat
        mem_do_rdata = 1'b1;
        mem_wordsize = 2'd1;
        reg_op1 = 32'h0000_1002;
        step();
        check("lh_addr",  mem_addr, 32'h0000_1000);
        check("lh_instr", mem_instr, 0);
        check("lh_wstrb", mem_wstrb, 0);
        mem_ready = 1'b1;
        mem_rdata = 32'hBEEF_1234;
        #1;
        check("lh_done",  mem_done, 1);
        check("lh_rword", mem_rdata_word, 32'h0000_BEEF);
        reg_op1 = 32'h0000_1000;
        #1;
        check("lh_low",   mem_rdata_word, 32'h0000_1234);
        mem_wordsize = 2'd2;
        reg_op1 = 32'h0000_1001;
        #1;
        check("lb_b1",    mem_rdata_word, 32'h0000_0012);
        reg_op1 = 32'h0000_1002;
        #1;
        check("lb_b2",    mem_rdata_word, 32'h0000_00EF);
        step();
        clear_req();
        mem_wordsize = 2'd0;
        mem_rdata = 32'h1122_3344;
        #1;
`ifdef OPICORV32_MEM_RDATA_HOLD_EN
        check("lh_after", mem_rdata_word, 32'hBEEF_1234);
`else
        check("lh_after", mem_rdata_word, 32'h1122_3344);
`endif

        // prefetch, then claim five cycles later
        mem_do_prefetch = 1'b1;
        next_pc = 32'h0000_0200;
        step();
        check("pf_valid", mem_valid, 1);
        check("pf_instr", mem_instr, 1);
        check("pf_addr",  mem_addr, 32'h0000_0200);
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #1;
        check("pf_nodone", mem_done, 0);
        step();
        clear_req();
        mem_rdata = 32'h0;
        #1;
        check("pf_state", 32'(dut.state), S_PREF);
        check("pf_valid_clr", mem_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("pf_idle_bus", mem_valid, 0);
        end
        step();
        mem_do_rinst = 1'b1;
        #1;
        check("pf_claim_done",  mem_done, 1);
        check("pf_claim_valid", mem_valid, 0);
`ifdef OPICORV32_MEM_RDATA_HOLD_EN
        check("pf_claim_data", mem_rdata_word, 32'hCAFE_F00D);
`endif
        step();
        mem_do_rinst = 1'b0;
        #1;
        check("pf_end_state", 32'(dut.state), S_IDLE);
        check("pf_end_valid", mem_valid, 0);

        // reset while in RWAIT
        mem_do_rdata = 1'b1;
        reg_op1 = 32'h0000_0040;
        step();
        check("ab_valid", mem_valid, 1);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("ab_done_forced", mem_done, 0);
        step();
        check("ab_valid_clr", mem_valid, 0);
        check("ab_state", 32'(dut.state), S_IDLE);
        check("ab_addr",  mem_addr, 0);
        reset = 1'b0;
        clear_req();

        // read and write together: read wins
        mem_do_rdata = 1'b1;
        mem_do_wdata = 1'b1;
        reg_op1 = 32'h0000_0080;
        reg_op2 = 32'h0000_0055;
        step();
        check("pr_state", 32'(dut.state), S_RWAIT);
        check("pr_wstrb", mem_wstrb, 0);
        check("pr_valid", mem_valid, 1);
        check("pr_instr", mem_instr, 0);
        mem_ready = 1'b1;
        step();
        clear_req();

        // trap blocks issue; ready with no valid is ignored
        trap = 1'b1;
        mem_do_rinst = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("tr_done", mem_done, 0);
        step();
        step();
        check("tr_valid", mem_valid, 0);
        check("tr_state", 32'(dut.state), S_IDLE);
        clear_req();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
